timekeeper_hms: RTL and testbench

Parametrised 24-hour HH:MM:SS timekeeper. Generates its own 1 Hz tick from the system clock via a prescaler. Supports:
- synchronous time load with range checking,
- a 12-hour display view,
- a minute-resolution alarm,
- second and day strobes.

It sits between the board clock domain and display/alarm logic, and supersedes the fixed 1 Hz-input counter.

---
 rtl/timekeeper_pkg.sv | 67 ++++++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/timekeeper_hms.sv | 105 ++++++++++
 tb/tb_timekeeper_hms.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/timekeeper_pkg.sv
// Shared types, field limits and time arithmetic helpers for the HH:MM:SS timekeeper.
package timekeeper_pkg;

  localparam int unsigned HH_W = 5;
  localparam int unsigned MS_W = 6;

  localparam logic [MS_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MS_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HH_W-1:0] HR_MAX  = 5'd23;
  localparam logic [HH_W-1:0] HR_NOON = 5'd12;

  typedef struct packed {
    logic [HH_W-1:0] hh;
    logic [MS_W-1:0] mm;
    logic [MS_W-1:0] ss;
  } time_t;

  typedef struct packed {
    logic [HH_W-1:0] hh_disp;
    logic            pm;
  } disp_t;

  // Midnight shows as 12 AM, noon as 12 PM.
  function automatic disp_t to_12h(input logic [HH_W-1:0] hh);
    disp_t r;
    if (hh == '0) begin
      r.hh_disp = HR_NOON;
      r.pm      = 1'b0;
    end else if (hh < HR_NOON) begin
      r.hh_disp = hh;
      r.pm      = 1'b0;
    end else if (hh == HR_NOON) begin
      r.hh_disp = HR_NOON;
      r.pm      = 1'b1;
    end else begin
      r.hh_disp = hh - HR_NOON;
      r.pm      = 1'b1;
    end
    return r;
  endfunction

  function automatic logic in_range(input time_t t);
    return (t.hh <= HR_MAX) && (t.mm <= MIN_MAX) && (t.ss <= SEC_MAX);
  endfunction

  function automatic logic is_last_sec(input time_t t);
    return (t.hh == HR_MAX) && (t.mm == MIN_MAX) && (t.ss == SEC_MAX);
  endfunction

  function automatic time_t inc_time(input time_t t);
    time_t r;
    r = t;
    if (t.ss == SEC_MAX) begin
      r.ss = '0;
      if (t.mm == MIN_MAX) begin
        r.mm = '0;
        r.hh = (t.hh == HR_MAX) ? '0 : t.hh + 5'd1;
      end else begin
        r.mm = t.mm + 6'd1;
      end
    end else begin
      r.ss = t.ss + 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
module tick_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned CNT_W         = $clog2(TICKS_PER_SEC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  // A clear restarts the second even if this cycle would have ticked.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timekeeper_hms.sv
// 24-hour HH:MM:SS timekeeper with internal 1 Hz prescaler, range-checked load,
// 12-hour display view, minute alarm and second/day strobes.
module timekeeper_hms
  import timekeeper_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned CNT_W         = $clog2(TICKS_PER_SEC + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_en,
  input  logic            set_valid,
  input  logic [HH_W-1:0] set_hh,
  input  logic [MS_W-1:0] set_mm,
  input  logic [MS_W-1:0] set_ss,
  input  logic            mode_12h,
  input  logic            alarm_en,
  input  logic [HH_W-1:0] alarm_hh,
  input  logic [MS_W-1:0] alarm_mm,
  output logic [HH_W-1:0] hh,
  output logic [MS_W-1:0] mm,
  output logic [MS_W-1:0] ss,
  output logic [HH_W-1:0] hh_disp,
  output logic            pm,
  output logic            sec_pulse,
  output logic            day_pulse,
  output logic            alarm_hit,
  output logic            set_err
);

  time_t time_q, time_d;
  time_t set_time;
  time_t adv_time;
  disp_t disp_12h;

  logic tick;
  logic load_ok;
  logic sec_pulse_q, sec_pulse_d;
  logic day_pulse_q, day_pulse_d;
  logic alarm_hit_q, alarm_hit_d;
  logic set_err_q, set_err_d;

  assign set_time = '{hh: set_hh, mm: set_mm, ss: set_ss};
  assign load_ok  = set_valid && in_range(set_time);
  assign adv_time = inc_time(time_q);

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .CNT_W        (CNT_W)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .clr (load_ok),
    .tick(tick)
  );

  // An accepted load overrides a coincident tick; the alarm only fires on a tick,
  // and since adv_time is always in range an out-of-range alarm never matches.
  always_comb begin
    time_d      = time_q;
    sec_pulse_d = 1'b0;
    day_pulse_d = 1'b0;
    alarm_hit_d = 1'b0;
    set_err_d   = set_valid && !load_ok;
    if (load_ok) begin
      time_d = set_time;
    end else if (tick) begin
      time_d      = adv_time;
      sec_pulse_d = 1'b1;
      day_pulse_d = is_last_sec(time_q);
      alarm_hit_d = alarm_en && (adv_time.hh == alarm_hh) &&
                    (adv_time.mm == alarm_mm) && (adv_time.ss == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q      <= '0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      alarm_hit_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      time_q      <= time_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
      alarm_hit_q <= alarm_hit_d;
      set_err_q   <= set_err_d;
    end
  end

  assign disp_12h = to_12h(time_q.hh);

  assign hh        = time_q.hh;
  assign mm        = time_q.mm;
  assign ss        = time_q.ss;
  assign hh_disp   = mode_12h ? disp_12h.hh_disp : time_q.hh;
  assign pm        = mode_12h && disp_12h.pm;
  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;
  assign alarm_hit = alarm_hit_q;
  assign set_err   = set_err_q;

endmodule

// File: tb/tb_timekeeper_hms.sv
// Directed bench for timekeeper_hms: one instance at 4 ticks/s, one at 1 tick/s for the day wrap.
module tb_timekeeper_hms;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_en = 1'b0;
  logic       set_valid = 1'b0;
  logic       run_en1 = 1'b0;
  logic       set_valid1 = 1'b0;
  logic [4:0] set_hh = '0;
  logic [5:0] set_mm = '0;
  logic [5:0] set_ss = '0;
  logic       mode_12h = 1'b0;
  logic       alarm_en = 1'b0;
  logic [4:0] alarm_hh = '0;
  logic [5:0] alarm_mm = '0;

  logic [4:0] hh, hh_disp, hh1, hh_disp1;
  logic [5:0] mm, ss, mm1, ss1;
  logic       pm, sec_pulse, day_pulse, alarm_hit, set_err;
  logic       pm1, sec_pulse1, day_pulse1, alarm_hit1, set_err1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  timekeeper_hms #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .set_valid(set_valid),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .mode_12h(mode_12h),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .hh(hh), .mm(mm), .ss(ss), .hh_disp(hh_disp), .pm(pm),
    .sec_pulse(sec_pulse), .day_pulse(day_pulse), .alarm_hit(alarm_hit), .set_err(set_err)
  );

  timekeeper_hms #(.TICKS_PER_SEC(1)) dut1 (
    .clk(clk), .rst(rst), .run_en(run_en1), .set_valid(set_valid1),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .mode_12h(mode_12h),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .hh(hh1), .mm(mm1), .ss(ss1), .hh_disp(hh_disp1), .pm(pm1),
    .sec_pulse(sec_pulse1), .day_pulse(day_pulse1), .alarm_hit(alarm_hit1), .set_err(set_err1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_time(input string tag, input int eh, input int em, input int es);
    check({tag, ".hh"}, int'(hh), eh);
    check({tag, ".mm"}, int'(mm), em);
    check({tag, ".ss"}, int'(ss), es);
  endtask

  task automatic load(input int h, input int m, input int s);
    set_hh = 5'(h);
    set_mm = 6'(m);
    set_ss = 6'(s);
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  initial begin
    // 1. Reset and tick rate
    step();
    step();
    check_time("rst", 0, 0, 0);
    check("rst.sec_pulse", int'(sec_pulse), 0);
    check("rst.set_err", int'(set_err), 0);
    check("rst.hh_disp24", int'(hh_disp), 0);
    mode_12h = 1'b1;
    #1;
    check("rst.hh_disp12", int'(hh_disp), 12);
    check("rst.pm12", int'(pm), 0);
    mode_12h = 1'b0;
    rst = 1'b0;
    run_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("rate.sec_pulse[%0d]", i), int'(sec_pulse), (i % 4 == 0) ? 1 : 0);
      check($sformatf("rate.ss[%0d]", i), int'(ss), i / 4);
    end

    // 3. Load colliding with a tick, then a rejected load
    step();
    step();
    step();
    load(10, 20, 30);
    check_time("coll", 10, 20, 30);
    check("coll.sec_pulse", int'(sec_pulse), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("coll.sec_pulse[%0d]", i), int'(sec_pulse), (i == 4) ? 1 : 0);
      check($sformatf("coll.ss[%0d]", i), int'(ss), (i == 4) ? 31 : 30);
    end
    load(24, 0, 0);
    check("bad.set_err", int'(set_err), 1);
    check_time("bad", 10, 20, 31);
    step();
    check("bad.set_err_off", int'(set_err), 0);

    // 2. Full-day wrap at one tick per cycle
    set_hh = 5'd23; set_mm = 6'd59; set_ss = 6'd58;
    set_valid1 = 1'b1;
    step();
    set_valid1 = 1'b0;
    run_en1 = 1'b1;
    check("wrap.load.ss", int'(ss1), 58);
    step();
    check("wrap1.hh", int'(hh1), 23);
    check("wrap1.mm", int'(mm1), 59);
    check("wrap1.ss", int'(ss1), 59);
    check("wrap1.day_pulse", int'(day_pulse1), 0);
    check("wrap1.sec_pulse", int'(sec_pulse1), 1);
    step();
    run_en1 = 1'b0;
    check("wrap2.hh", int'(hh1), 0);
    check("wrap2.mm", int'(mm1), 0);
    check("wrap2.ss", int'(ss1), 0);
    check("wrap2.day_pulse", int'(day_pulse1), 1);
    check("wrap2.hh_disp", int'(hh_disp1), 0);
    check("wrap2.pm", int'(pm1), 0);
    check("wrap2.alarm_hit", int'(alarm_hit1), 0);
    check("wrap2.set_err", int'(set_err1), 0);
    step();
    check("wrap3.day_pulse", int'(day_pulse1), 0);

    // 4. 12-hour view
    run_en = 1'b0;
    mode_12h = 1'b1;
    load(0, 0, 0);
    check("v12.00.hh_disp", int'(hh_disp), 12);
    check("v12.00.pm", int'(pm), 0);
    load(12, 0, 0);
    check("v12.12.hh_disp", int'(hh_disp), 12);
    check("v12.12.pm", int'(pm), 1);
    load(13, 5, 0);
    check("v12.13.hh_disp", int'(hh_disp), 1);
    check("v12.13.pm", int'(pm), 1);
    check("v12.13.mm", int'(mm), 5);
    load(11, 0, 0);
    check("v12.11.hh_disp", int'(hh_disp), 11);
    check("v12.11.pm", int'(pm), 0);
    load(23, 0, 0);
    check("v12.23.hh_disp", int'(hh_disp), 11);
    check("v12.23.pm", int'(pm), 1);
    mode_12h = 1'b0;
    #1;
    check("v24.23.hh_disp", int'(hh_disp), 23);
    check("v24.23.pm", int'(pm), 0);

    // 5. Alarm
    alarm_en = 1'b1;
    alarm_hh = 5'd7;
    alarm_mm = 6'd30;
    run_en = 1'b1;
    load(7, 29, 59);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("alarm.hit[%0d]", i), int'(alarm_hit), (i == 4) ? 1 : 0);
    end
    check_time("alarm", 7, 30, 0);
    step();
    check("alarm.hit_off", int'(alarm_hit), 0);
    run_en = 1'b0;
    load(7, 30, 0);
    check("alarm.load.hit", int'(alarm_hit), 0);
    step();
    check("alarm.load.hit2", int'(alarm_hit), 0);
    alarm_en = 1'b0;
    run_en = 1'b1;
    load(7, 29, 59);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("alarm.dis.hit[%0d]", i), int'(alarm_hit), 0);
    end
    check_time("alarm.dis", 7, 30, 0);

    // 6. Pause mid-second, then reset mid-second
    step();
    step();
    run_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("pause.ss[%0d]", i), int'(ss), 0);
      check($sformatf("pause.sec_pulse[%0d]", i), int'(sec_pulse), 0);
    end
    run_en = 1'b1;
    step();
    check("resume.sec_pulse1", int'(sec_pulse), 0);
    step();
    check("resume.sec_pulse2", int'(sec_pulse), 1);
    check("resume.ss", int'(ss), 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_time("midrst", 0, 0, 0);
    check("midrst.sec_pulse", int'(sec_pulse), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("midrst.sec_pulse[%0d]", i), int'(sec_pulse), (i == 4) ? 1 : 0);
    end
    check("midrst.ss", int'(ss), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
